// File: rtl/rx_packet_queue.sv
// rx_packet_queue: store-and-forward MAC-to-AXIS receive queue; define RX_PACKET_QUEUE_STATS_EN to build the frame counters
module rx_packet_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic [DATA_WIDTH/8-1:0] rx_strb,
    input  logic                    rx_data_valid,
    input  logic                    rx_good_frame,
    input  logic                    rx_bad_frame,
    output logic [DATA_WIDTH-1:0]   tdata,
    output logic [DATA_WIDTH/8-1:0] tstrb,
    output logic                    tvalid,
    output logic                    tlast,
    input  logic                    tready,
    output logic [31:0]             good_frame_count,
    output logic [31:0]             bad_frame_count,
    output logic [31:0]             overflow_drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + SW + 1;

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_STATUS, W_DROP} w_state_e;

    logic [EW-1:0]         mem [DEPTH];
    w_state_e              state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;
    logic [SW-1:0]         stg_strb_q, stg_strb_d;
    logic [EW-1:0]         out_q, out_d;
    logic                  tvalid_q, tvalid_d;
    logic                  first_q;
    logic [PW-1:0]         free;
    logic                  status, status_due, overflow, load;
    logic                  wr_en, wr_last;
    logic [SW-1:0]         wr_strb;
    logic                  inc_good, inc_bad, inc_ovf;

    assign free       = PW'(DEPTH) - (wr_ptr_q - rd_ptr_q);
    assign status     = rx_good_frame || rx_bad_frame;
    assign overflow   = state_q == W_WRITE && free == '0;
    assign status_due = (state_q == W_WRITE && !rx_data_valid) || state_q == W_STATUS;
    assign load       = rd_ptr_q != commit_ptr_q && (!tvalid_q || tready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= W_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            stg_data_q   <= '0;
            stg_strb_q   <= '0;
            out_q        <= '0;
            tvalid_q     <= 1'b0;
            first_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            stg_data_q   <= stg_data_d;
            stg_strb_q   <= stg_strb_d;
            out_q        <= out_d;
            tvalid_q     <= tvalid_d;
            first_q      <= 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (wr_en && !reset) mem[wr_ptr_q[AW-1:0]] <= {wr_last, wr_strb, stg_data_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:   if (rx_data_valid) state_d = first_q ? W_DROP : W_WRITE;
            W_WRITE:
                if (overflow) state_d = (!rx_data_valid && status) ? W_IDLE : W_DROP;
                else if (!rx_data_valid) state_d = status ? W_IDLE : W_STATUS;
            W_STATUS: if (status) state_d = W_IDLE;
            W_DROP:   if (!rx_data_valid && status) state_d = W_IDLE;
        endcase
    end

    always_comb begin
        wr_en        = state_q == W_WRITE && !overflow;
        wr_last      = !rx_data_valid;
        wr_strb      = wr_last ? stg_strb_q : {SW{1'b1}};
        inc_good     = !overflow && status_due && rx_good_frame;
        inc_bad      = !overflow && status_due && rx_bad_frame;
        inc_ovf      = (overflow || state_q == W_DROP) && !rx_data_valid && status;
        wr_ptr_d     = (overflow || inc_bad) ? commit_ptr_q : wr_ptr_q + PW'(wr_en);
        commit_ptr_d = inc_good ? wr_ptr_d : commit_ptr_q;
        stg_data_d   = rx_data_valid ? rx_data : stg_data_q;
        stg_strb_d   = rx_data_valid ? rx_strb : stg_strb_q;
        rd_ptr_d     = rd_ptr_q + PW'(load);
        tvalid_d     = load || (tvalid_q && !tready);
        out_d        = load ? mem[rd_ptr_q[AW-1:0]] : out_q;
    end

    assign tvalid = tvalid_q;
    assign {tlast, tstrb, tdata} = out_q;

`ifdef RX_PACKET_QUEUE_STATS_EN
    logic [31:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d, ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        good_cnt_d = good_cnt_q + 32'(inc_good && good_cnt_q != '1);
        bad_cnt_d  = bad_cnt_q + 32'(inc_bad && bad_cnt_q != '1);
        ovf_cnt_d  = ovf_cnt_q + 32'(inc_ovf && ovf_cnt_q != '1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign good_frame_count    = good_cnt_q;
    assign bad_frame_count     = bad_cnt_q;
    assign overflow_drop_count = ovf_cnt_q;
`else
    logic unused_inc;

    assign unused_inc          = inc_good ^ inc_bad ^ inc_ovf;
    assign good_frame_count    = '0;
    assign bad_frame_count     = '0;
    assign overflow_drop_count = '0;
`endif
endmodule

// File: doc/rx_packet_queue.md
# rx_packet_queue

Single-clock, store-and-forward receive queue between a MAC receive interface and the AXI4-Stream receive path of the 1G/10G interface cores. Generalises the byte-wide receive converter to any power-of-two data width and configurable depth. Frames are buffered speculatively. A frame is released to AXI only after the MAC reports it good. Bad frames, overflowing frames and frames interrupted by reset are discarded in place, so no error sideband is needed downstream.

## Interface
- `DATA_WIDTH`, default 64: datapath width in bits; allowed values are 8, 16, 32, 64, 128 or 256.
- `DEPTH`, default 512: storage entries; a power of two, ≥ 4.
- `clk` input, 1: the single clock for the block.
- `reset` input, 1: synchronous, active-high.
- `rx_data` input, DATA_WIDTH: MAC beat data.
- `rx_strb` input, DATA_WIDTH/8: byte enables; sampled on the last beat only.
- `rx_data_valid` input, 1: high for every beat of a frame, contiguous; low between frames.
- `rx_good_frame` input, 1: one-cycle pulse, one per frame.
- `rx_bad_frame` input, 1: one-cycle pulse, one per frame; never asserted together with `rx_good_frame`.
- `tdata` output, DATA_WIDTH: AXI data.
- `tstrb` output, DATA_WIDTH/8: AXI byte strobes.
- `tvalid` output, 1: AXI valid.
- `tlast` output, 1: AXI last.
- `tready` input, 1: AXI ready.
- `good_frame_count` output, 32: frames committed.
- `bad_frame_count` output, 32: frames dropped on `rx_bad_frame`.
- `overflow_drop_count` output, 32: frames dropped for lack of space or because of reset.

## Operation
- Storage holds `DEPTH` entries, each `{last, strb, data}`.
- The block keeps three pointers of width log2(DEPTH)+1: `wr_ptr` (speculative), `commit_ptr` and `rd_ptr`.
- free = DEPTH − (wr_ptr − rd_ptr), computed modulo 2^(log2(DEPTH)+1).
- A one-entry staging register holds the most recent beat, because a beat is known to be last only when `rx_data_valid` falls.
- Write FSM states:
  - W_IDLE: when `rx_data_valid` is high, load staging and go to W_WRITE.
  - W_WRITE:
    - While `rx_data_valid` is high, write staging to storage with last=0 and strb all-ones, then reload staging.
    - On the first cycle `rx_data_valid` is low, write staging with last=1 and strb = the `rx_strb` captured with that beat, then go to W_STATUS.
    - If a write is due while free == 0, set `wr_ptr` ← `commit_ptr` and go to W_DROP.
  - W_STATUS:
    - `rx_good_frame`: `commit_ptr` ← `wr_ptr`, go to W_IDLE.
    - `rx_bad_frame`: `wr_ptr` ← `commit_ptr`, increment bad_frame_count, go to W_IDLE.
  - W_DROP: wait for `rx_data_valid` low, then for either status pulse; increment overflow_drop_count and go to W_IDLE.
- A status pulse that coincides with the last-beat write cycle is honoured in that cycle. The commit includes the word being written.
- A frame longer than DEPTH entries is always dropped.
- Read side: a single-entry output register is loaded from `rd_ptr` whenever it is empty or being consumed, provided `rd_ptr` ≠ `commit_ptr`. `rd_ptr` increments on each load.

## Timing
- Reset values: `tvalid`=0, `tlast`=0, `tdata`=0, `tstrb`=0, all counters 0, all pointers 0, FSM in W_IDLE.
- Mid-frame reset: if `rx_data_valid` is high in the first cycle after reset releases, the FSM enters W_DROP. The partial frame is discarded and counted in overflow_drop_count.
- Latency: the first beat of a frame is on `tvalid` two cycles after the cycle in which its good-status pulse is sampled.
- Throughput: one beat per cycle while `tready`=1.
- AXI handshake:
  - `tdata`, `tstrb` and `tlast` stay stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never drops without a transfer.
- `tlast`=1 only on the final beat of a frame. Non-last beats have `tstrb` all ones.
- The read and write sides operate concurrently. A rollback never moves `wr_ptr` below `commit_ptr`.
- Counters saturate at 0xFFFFFFFF.

## Configuration
- `RX_PACKET_QUEUE_STATS_EN` defined: the three counters are implemented as specified above.
- Macro undefined: counters are not built and the count outputs are tied to 0. Datapath behaviour is identical in both cases.

## Test plan
- Single good frame: DATA_WIDTH=64, 3 beats, last `rx_strb`=0x0F, good pulse → 3 AXI beats with `tlast` on beat 3 and `tstrb`=0xFF, 0xFF, 0x0F; `tvalid` rises 2 cycles after the pulse; good_frame_count=1.
- Bad frame between two good frames (4 beats each) → only the 8 good beats appear on AXI; bad_frame_count=1; free space is restored to DEPTH after draining.
- Overflow: DEPTH=16 with `tready`=0 and a 20-beat frame → no AXI output; overflow_drop_count=1. A following 4-beat good frame is delivered intact.
- Status coincident with the last-beat write, with `tready` toggling 1/0 every cycle → all beats are delivered in order and outputs stay stable while stalled.
- Reset asserted for 1 cycle mid-frame (beat 2 of 5) → the remainder of that frame is dropped and overflow_drop_count=1; the next good frame is delivered.
- With `RX_PACKET_QUEUE_STATS_EN` undefined, repeat the bad-frame scenario → identical AXI output and all counters read 0.
